seq_mem_arbiter: RTL and testbench
==================================

# seq_mem_arbiter

Arbitrates the shared sequence memory between the player-input loader (write bursts) and the playback engine (read bursts). Grants one requester at a time for a fixed-length burst, drives the memory enable/write/address, and counts completed bursts for the game FSM's win check. Sits between the game FSM's load/read strobes and the sequence RAM.

## Interface
- ADDR_W, 4, memory address width
- BURST_LEN, 16, beats per burst; legal range 1..2^ADDR_W
- ROUND_W, 9, width of completed-burst counter
- WD_CYCLES, 31, idle-beat limit before watchdog abort (used only with ARB_WATCHDOG_EN)
- clka  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_req  in  1  loader requests a write burst
- ld_valid  in  1  loader beat strobe: write data valid this cycle
- pb_req  in  1  playback requests a read burst
- pb_ready  in  1  playback beat strobe: ready to take a read this cycle
- abort  in  1  synchronous cancel of the current burst
- ld_gnt  out  1  loader owns memory
- pb_gnt  out  1  playback owns memory
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write when 1, read when 0
- mem_addr  out  ADDR_W  memory address
- burst_done  out  1  one-cycle pulse: burst completed
- round_cnt  out  ROUND_W  completed bursts, saturating
- busy  out  1  any grant active or DONE in progress
- timeout  out  1  one-cycle watchdog pulse (constant 0 without macro)

## Operation
- States: IDLE, GNT_LD, GNT_PB, DONE.
- IDLE: only ld_req -> GNT_LD; only pb_req -> GNT_PB; both -> grant the requester not in last_served; neither -> stay.
- last_served updates on entry to a grant state; reset value = playback, so loader wins the first tie.
- GNT_LD: ld_gnt=1; each cycle with ld_valid=1 is one beat: mem_en=1, mem_we=1, mem_addr=beat_cnt.
- GNT_PB: pb_gnt=1; each cycle with pb_ready=1 is one beat: mem_en=1, mem_we=0, mem_addr=beat_cnt.
- beat_cnt (ADDR_W bits) clears on grant entry, increments per beat; beat with beat_cnt==BURST_LEN-1 -> DONE.
- Grant held for whole burst; deasserting req mid-burst is ignored.
- DONE: one cycle, burst_done=1, round_cnt+1 unless already all-ones (saturate); then IDLE. Both burst types count.
- abort=1 in GNT_LD/GNT_PB: no beat that cycle (mem_en=0), next state IDLE, beat_cnt cleared, no burst_done, round_cnt unchanged. abort in IDLE/DONE ignored.
- abort and last beat in same cycle: abort wins.
- busy = ld_gnt | pb_gnt | (state==DONE).

## Timing
- Reset (async, reset=0): state IDLE, all outputs 0, beat_cnt 0, round_cnt 0, last_served=playback, watchdog count 0.
- State, gnts, beat_cnt, round_cnt, burst_done, timeout registered; mem_en/mem_we/mem_addr combinational from state, beat_cnt and strobe (same-cycle).
- Request sampled in IDLE cycle N -> gnt high from N+1; beats accepted from N+1.
- Minimum burst: 1 (grant) ... BURST_LEN beat cycles, DONE 1 cycle, IDLE ≥1 cycle; back-to-back grants separated by DONE+IDLE = 2 cycles.
- Reset asserted mid-burst: immediate return to reset values; partial burst lost, no burst_done.

## Configuration
- ARB_WATCHDOG_EN defined: counter clears on grant entry and on each beat, increments on grant cycles without beat; reaching WD_CYCLES -> timeout=1 for one cycle, next state IDLE, no burst_done, round_cnt unchanged. abort has priority over watchdog in same cycle.
- Undefined: no counter, timeout tied 0, a stalled grant waits indefinitely.

## Test plan
- ld_req alone, ld_valid held 1 -> ld_gnt next cycle, 16 writes at addr 0..15, burst_done 1 cycle after addr 15, round_cnt=1.
- ld_req and pb_req together from reset -> loader first; both held -> pb_gnt after DONE+IDLE, alternating thereafter.
- pb_ready toggling 1/0 -> reads at addr 0..15 only on ready cycles, burst_done after 16th beat.
- abort at beat 5 -> mem_en 0 that cycle, IDLE next, no burst_done, round_cnt unchanged; next burst restarts at addr 0.
- ROUND_W=2, 5 bursts -> round_cnt 1,2,3,3,3.
- With ARB_WATCHDOG_EN, grant with no strobes -> timeout pulse after 31 idle grant cycles, IDLE next; without macro, grant persists and timeout stays 0.

Source files
------------

// File: rtl/seq_mem_arbiter_if.sv
// Bus bundle between the game FSM strobes, the sequence RAM and seq_mem_arbiter.
// master = requester/memory side, slave = arbiter.
interface seq_mem_arbiter_if #(
  parameter int ADDR_W  = 4,
  parameter int ROUND_W = 9
);
  logic               ld_req;
  logic               ld_valid;
  logic               pb_req;
  logic               pb_ready;
  logic               abort;
  logic               ld_gnt;
  logic               pb_gnt;
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic               burst_done;
  logic [ROUND_W-1:0] round_cnt;
  logic               busy;
  logic               timeout;

  modport master (
    output ld_req, ld_valid, pb_req, pb_ready, abort,
    input  ld_gnt, pb_gnt, mem_en, mem_we, mem_addr, burst_done, round_cnt, busy, timeout
  );

  modport slave (
    input  ld_req, ld_valid, pb_req, pb_ready, abort,
    output ld_gnt, pb_gnt, mem_en, mem_we, mem_addr, burst_done, round_cnt, busy, timeout
  );
endinterface

// File: rtl/seq_mem_arbiter.sv
// Fixed-length burst arbiter for the shared sequence RAM (loader writes, playback reads).
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module seq_mem_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int BURST_LEN = 16,
  parameter int ROUND_W   = 9,
  parameter int WD_CYCLES = 31
) (
  input  logic             clka,
  input  logic             reset,
  seq_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_LD = 2'd1,
    ST_GNT_PB = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > (1 << ADDR_W) || WD_CYCLES < 1) begin : g_bad_cfg
    $error("seq_mem_arbiter: illegal BURST_LEN or WD_CYCLES");
  end

  state_t             state_r;
  state_t             state_nx_s;
  logic [ADDR_W-1:0]  beat_cnt_r;
  logic [ADDR_W-1:0]  beat_cnt_nx_s;
  logic               last_pb_r;      // 1 when playback was the last requester granted
  logic               last_pb_nx_s;
  logic [ROUND_W-1:0] round_cnt_r;
  logic [ROUND_W-1:0] round_cnt_nx_s;
  logic               ld_gnt_r;
  logic               pb_gnt_r;
  logic               burst_done_r;
  logic               busy_r;
  logic               granted_s;
  logic               strobe_s;
  logic               beat_s;

`ifdef ARB_WATCHDOG_EN
  localparam int            WD_W    = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt_r;
  logic [WD_W-1:0] wd_cnt_nx_s;
  logic            timeout_r;
  logic            timeout_nx_s;
`endif

  // Beat qualification: owner's strobe, suppressed by abort
  always_comb begin
    granted_s = (state_r == ST_GNT_LD) || (state_r == ST_GNT_PB);
    strobe_s  = (state_r == ST_GNT_LD) ? bus.ld_valid : bus.pb_ready;
    beat_s    = granted_s && strobe_s && !bus.abort;
  end

  assign bus.mem_en   = beat_s;
  assign bus.mem_we   = beat_s && (state_r == ST_GNT_LD);
  assign bus.mem_addr = beat_cnt_r;

  // Next-state, burst counting and saturating round counter
  always_comb begin
    state_nx_s     = state_r;
    beat_cnt_nx_s  = beat_cnt_r;
    last_pb_nx_s   = last_pb_r;
    round_cnt_nx_s = round_cnt_r;
`ifdef ARB_WATCHDOG_EN
    wd_cnt_nx_s    = wd_cnt_r;
    timeout_nx_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.ld_req && (!bus.pb_req || last_pb_r)) begin
          state_nx_s    = ST_GNT_LD;
          last_pb_nx_s  = 1'b0;
          beat_cnt_nx_s = '0;
`ifdef ARB_WATCHDOG_EN
          wd_cnt_nx_s   = '0;
`endif
        end else if (bus.pb_req) begin
          state_nx_s    = ST_GNT_PB;
          last_pb_nx_s  = 1'b1;
          beat_cnt_nx_s = '0;
`ifdef ARB_WATCHDOG_EN
          wd_cnt_nx_s   = '0;
`endif
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_GNT_LD, ST_GNT_PB: begin
        if (bus.abort) begin
          state_nx_s    = ST_IDLE;
          beat_cnt_nx_s = '0;
        end else if (beat_s) begin
`ifdef ARB_WATCHDOG_EN
          wd_cnt_nx_s = '0;
`endif
          if (beat_cnt_r == LAST_BEAT) begin
            state_nx_s     = ST_DONE;
            beat_cnt_nx_s  = '0;
            round_cnt_nx_s = (&round_cnt_r) ? round_cnt_r : round_cnt_r + 1'b1;
          end else begin
            beat_cnt_nx_s = beat_cnt_r + 1'b1;
          end
        end else begin
`ifdef ARB_WATCHDOG_EN
          if (wd_cnt_r == WD_LAST) begin
            state_nx_s    = ST_IDLE;
            beat_cnt_nx_s = '0;
            wd_cnt_nx_s   = '0;
            timeout_nx_s  = 1'b1;
          end else begin
            wd_cnt_nx_s = wd_cnt_r + 1'b1;
          end
`else
          state_nx_s = state_r;
`endif
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      beat_cnt_r   <= '0;
      last_pb_r    <= 1'b1;
      round_cnt_r  <= '0;
      ld_gnt_r     <= 1'b0;
      pb_gnt_r     <= 1'b0;
      burst_done_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef ARB_WATCHDOG_EN
      wd_cnt_r     <= '0;
      timeout_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_nx_s;
      beat_cnt_r   <= beat_cnt_nx_s;
      last_pb_r    <= last_pb_nx_s;
      round_cnt_r  <= round_cnt_nx_s;
      ld_gnt_r     <= (state_nx_s == ST_GNT_LD);
      pb_gnt_r     <= (state_nx_s == ST_GNT_PB);
      burst_done_r <= (state_nx_s == ST_DONE);
      busy_r       <= (state_nx_s != ST_IDLE);
`ifdef ARB_WATCHDOG_EN
      wd_cnt_r     <= wd_cnt_nx_s;
      timeout_r    <= timeout_nx_s;
`endif
    end
  end

  assign bus.ld_gnt     = ld_gnt_r;
  assign bus.pb_gnt     = pb_gnt_r;
  assign bus.burst_done = burst_done_r;
  assign bus.round_cnt  = round_cnt_r;
  assign bus.busy       = busy_r;
`ifdef ARB_WATCHDOG_EN
  assign bus.timeout    = timeout_r;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// Randomized bench for seq_mem_arbiter against a burst-level reference model.
// Honours ARB_WATCHDOG_EN the same way the design does.
module tb_seq_mem_arbiter;
  localparam int ADDR_W = 4;
  localparam int BL     = 16;
  localparam int RW     = 9;
  localparam int WD     = 31;
  localparam int RMAX   = (1 << RW) - 1;

  logic clka;
  logic reset;
  int   n_total = 0;
  int   n_bad   = 0;

  // owner: 0 none, 1 loader, 2 playback; last: who was granted last
  int m_owner, m_done, m_beats, m_last, m_rounds, m_idle, m_to;

  seq_mem_arbiter_if #(.ADDR_W(ADDR_W), .ROUND_W(RW)) bus ();

  seq_mem_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .ROUND_W(RW), .WD_CYCLES(WD)) dut (
    .clka  (clka),
    .reset (reset),
    .bus   (bus)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_done = 0; m_beats = 0; m_last = 2; m_rounds = 0; m_idle = 0; m_to = 0;
  endtask

  task automatic model_step();
    int strobe;
    m_to = 0;
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_owner == 0) begin
      if (bus.ld_req && (!bus.pb_req || m_last == 2)) begin
        m_owner = 1; m_last = 1; m_beats = 0; m_idle = 0;
      end else if (bus.pb_req) begin
        m_owner = 2; m_last = 2; m_beats = 0; m_idle = 0;
      end
    end else begin
      strobe = (m_owner == 1) ? int'(bus.ld_valid) : int'(bus.pb_ready);
      if (bus.abort) begin
        m_owner = 0; m_beats = 0;
      end else if (strobe != 0) begin
        m_idle = 0;
        m_beats++;
        if (m_beats == BL) begin
          m_owner = 0; m_beats = 0; m_done = 1;
          if (m_rounds < RMAX) m_rounds++;
        end
      end else begin
        m_idle++;
`ifdef ARB_WATCHDOG_EN
        if (m_idle == WD) begin
          m_owner = 0; m_beats = 0; m_to = 1;
        end
`endif
      end
    end
  endtask

  task automatic check_outputs();
    logic strobe, exp_en;
    strobe = (m_owner == 1) ? bus.ld_valid : bus.pb_ready;
    exp_en = (m_owner != 0) && strobe && !bus.abort;
    chk("ld_gnt", 32'(bus.ld_gnt), 32'(m_owner == 1));
    chk("pb_gnt", 32'(bus.pb_gnt), 32'(m_owner == 2));
    chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
    if (exp_en) begin
      chk("mem_we", 32'(bus.mem_we), 32'(m_owner == 1));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_beats));
    end
    chk("burst_done", 32'(bus.burst_done), 32'(m_done));
    chk("round_cnt", 32'(bus.round_cnt), 32'(m_rounds));
    chk("busy", 32'(bus.busy), 32'((m_owner != 0) || (m_done != 0)));
    chk("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic cycle();
    @(negedge clka);
    check_outputs();
    @(posedge clka);
    model_step();
    #1;
  endtask

  task automatic drive(input logic lr, input logic lv, input logic pr, input logic py, input logic ab);
    bus.ld_req = lr; bus.ld_valid = lv; bus.pb_req = pr; bus.pb_ready = py; bus.abort = ab;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(negedge clka);
    reset = 1'b1;
    @(posedge clka);
    model_step();
    #1;
  endtask

  initial begin
    bit aborted;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    do_reset();
    chk("rst_round_cnt", 32'(bus.round_cnt), 32'd0);

    // Loader alone, valid held
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();
    chk("single_burst_rounds", 32'(bus.round_cnt), 32'd1);

    // Playback burst interrupted by reset, then tie from reset
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (6) cycle();
    do_reset();
    chk("midburst_reset_pb_gnt", 32'(bus.pb_gnt), 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("tie_loader_first", 32'(bus.ld_gnt), 32'd1);
    repeat (60) cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) cycle();

    // Playback with ready toggling
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b0, 1'b0, i[0], 1'b0);
      cycle();
    end

    // Abort at beat 5, then a fresh burst from address 0
    aborted = 1'b0;
    for (int i = 0; i < 45; i++) begin
      drive(i < 25, 1'b1, 1'b0, 1'b0, !aborted && m_owner == 1 && m_beats == 5);
      if (bus.abort) aborted = 1'b1;
      cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();

    // Stalled grant: no strobes
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();

    // Random traffic, long enough to saturate the round counter
    for (int i = 0; i < 25000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 63) == 0));
      cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) cycle();
    chk("round_cnt_saturated", 32'(bus.round_cnt), 32'(RMAX));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
